// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage in front of the ALU: decodes RV32I OP/OP-IMM into
// (A, B, alu_op, rd, illegal) and buffers the result in a 2-entry skid buffer.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] shamt;
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [31:0] dec_b;
    bundle_t     dec_bundle;

    bundle_t     main_reg;
    bundle_t     skid_reg;
    logic        main_valid_reg;
    logic        skid_valid_reg;
    logic        in_hs;
    logic        out_hs;

    // Register indices are consumed by the register file, not here.
    logic        unused_rs1_idx;
    assign unused_rs1_idx = ^instr[19:15];

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_b     = 32'd0;
        case (opcode)
            OPC_OP: begin
                dec_b = rs2_data;
                case (f3)
                    3'b000: begin
                        dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b101: begin
                        dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    3'b001: begin dec_legal = (f7 == F7_BASE); dec_op = ALU_SLL;  end
                    3'b010: begin dec_legal = (f7 == F7_BASE); dec_op = ALU_SLT;  end
                    3'b011: begin dec_legal = (f7 == F7_BASE); dec_op = ALU_SLTU; end
                    3'b100: begin dec_legal = (f7 == F7_BASE); dec_op = ALU_XOR;  end
                    3'b110: begin dec_legal = (f7 == F7_BASE); dec_op = ALU_OR;   end
                    default: begin dec_legal = (f7 == F7_BASE); dec_op = ALU_AND; end
                endcase
            end
            OPC_OP_IMM: begin
                dec_b     = imm_i;
                dec_legal = 1'b1;
                case (f3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_b     = shamt;
                        dec_legal = (f7 == F7_BASE);
                        dec_op    = ALU_SLL;
                    end
                    default: begin
                        dec_b     = shamt;
                        dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Illegal encodings still issue, but as an all-zero bundle with the flag set.
    always_comb begin
        dec_bundle = '0;
        if (dec_legal) begin
            dec_bundle.a  = rs1_data;
            dec_bundle.b  = dec_b;
            dec_bundle.op = dec_op;
            dec_bundle.rd = instr[11:7];
        end else begin
            dec_bundle.illegal = 1'b1;
        end
    end

    assign in_ready = ~skid_valid_reg;
    assign in_hs    = in_valid & ~skid_valid_reg;
    assign out_hs   = main_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (out_hs) begin
                main_reg       <= skid_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (in_hs) begin
            if (!main_valid_reg || out_hs) begin
                main_reg       <= dec_bundle;
                main_valid_reg <= 1'b1;
            end else begin
                skid_reg       <= dec_bundle;
                skid_valid_reg <= 1'b1;
            end
        end else if (out_hs) begin
            main_valid_reg <= 1'b0;
        end
    end

    assign out_valid = main_valid_reg;
    assign A         = main_reg.a;
    assign B         = main_reg.b;
    assign alu_op    = main_reg.op;
    assign rd        = main_reg.rd;
    assign illegal   = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expected bundles.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        illegal;

    int n_chk  = 0;
    int n_fail = 0;

    alu_issue_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .A        (A),
        .B        (B),
        .alu_op   (alu_op),
        .rd       (rd),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } bundle_t;

    // alu_op for each funct3 in its base (f7=0) form; the alternate f7 bumps ADD->SUB, SRL->SRA.
    localparam logic [3:0] F3_OP [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};

    function automatic bundle_t ref_decode(logic [31:0] w, logic [31:0] r1, logic [31:0] r2);
        bundle_t    r     = '0;
        logic [6:0] opc   = w[6:0];
        logic [2:0] fn3   = w[14:12];
        logic [6:0] fn7   = w[31:25];
        bit         is_op = (opc == 7'h33);
        bit         is_im = (opc == 7'h13);
        bit         shift = (fn3 == 3'd1) || (fn3 == 3'd5);
        bit         alt   = (fn7 == 7'h20);
        bit         ok;
        if (is_op)      ok = (fn7 == 7'h00) || (alt && (fn3 == 3'd0 || fn3 == 3'd5));
        else if (is_im) ok = !shift || (fn7 == 7'h00) || (alt && fn3 == 3'd5);
        else            ok = 1'b0;
        if (!ok) begin
            r.ill = 1'b1;
            return r;
        end
        r.a  = r1;
        r.op = F3_OP[fn3];
        if (alt && (fn3 == 3'd5 || (is_op && fn3 == 3'd0))) r.op = r.op + 4'd1;
        if (is_op)      r.b = r2;
        else if (shift) r.b = {27'b0, w[24:20]};
        else            r.b = {{20{w[31]}}, w[31:20]};
        r.rd = w[11:7];
        return r;
    endfunction

    // Reference buffer: a FIFO of capacity 2 whose head drives the outputs.
    bundle_t q[$];
    bit      m_push, m_pop;
    bundle_t m_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() < 2);
            m_pop  = (q.size() > 0) && out_ready;
            m_new  = ref_decode(instr, rs1_data, rs2_data);
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(m_new);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    bundle_t got;
    always @(negedge clk) begin
        got = '{a: A, b: B, op: alu_op, rd: rd, ill: illegal};
        chk("model_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("model_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        if (out_valid && q.size() > 0) begin
            n_chk++;
            if (got !== q[0]) begin
                n_fail++;
                $display("FAIL model_bundle: got A=%h B=%h op=%0d rd=%0d ill=%0b expected A=%h B=%h op=%0d rd=%0d ill=%0b",
                         got.a, got.b, got.op, got.rd, got.ill,
                         q[0].a, q[0].b, q[0].op, q[0].rd, q[0].ill);
            end
        end
        if (rst_n && out_valid && out_ready)
            $display("issue A=%h B=%h op=%0d rd=%0d ill=%0b", A, B, alu_op, rd, illegal);
    end

    task automatic chk_out(string name, logic [31:0] ea, logic [31:0] eb,
                           logic [3:0] eop, logic [4:0] erd, logic eill);
        chk({name, "_valid"},   {31'b0, out_valid}, 32'd1);
        chk({name, "_A"},       A, ea);
        chk({name, "_B"},       B, eb);
        chk({name, "_op"},      {28'b0, alu_op}, {28'b0, eop});
        chk({name, "_rd"},      {27'b0, rd}, {27'b0, erd});
        chk({name, "_illegal"}, {31'b0, illegal}, {31'b0, eill});
    endtask

    // Present one instruction for a single cycle; on return it sits in main.
    task automatic send(logic [31:0] w, logic [31:0] r1, logic [31:0] r2);
        @(posedge clk); #1;
        in_valid = 1'b1; instr = w; rs1_data = r1; rs2_data = r2;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    int stream_ok;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        #7;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_A",         A, 32'd0);
        chk("rst_illegal",   {31'b0, illegal},   32'd0);
        #5 rst_n = 1'b1;
        step();
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_in_ready",  {31'b0, in_ready},  32'd1);

        // Basic issue and decode vectors
        send(32'h002081B3, 32'd5, 32'd7);
        chk_out("add", 32'd5, 32'd7, 4'd0, 5'd3, 1'b0);
        send(32'hFFF00093, 32'd0, 32'h1234);
        chk_out("addi", 32'd0, 32'hFFFFFFFF, 4'd0, 5'd1, 1'b0);
        send(32'h40415113, 32'h80000000, 32'h55);
        chk_out("srai", 32'h80000000, 32'd4, 4'd7, 5'd2, 1'b0);
        send(32'h40208033, 32'd9, 32'd3);
        chk_out("sub", 32'd9, 32'd3, 4'd1, 5'd0, 1'b0);

        // Back-pressure: three pushes with out_ready low
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd10; rs2_data = 32'd1;
        step(); rs1_data = 32'd11;
        step(); rs1_data = 32'd12;
        chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_A0",       A, 32'd10);
        step();
        chk("bp_still_full",    {31'b0, in_ready}, 32'd0);
        chk("bp_hold_A1",       A, 32'd10);
        out_ready = 1'b1;
        step();
        chk("bp_drain_A11",     A, 32'd11);
        chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_drain_A12",     A, 32'd12);
        in_valid = 1'b0;
        step();
        chk("bp_empty",         {31'b0, out_valid}, 32'd0);

        // Streaming: one per cycle with both handshakes held high
        stream_ok = 0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                if (out_valid && A == 32'd100 + 32'(k - 1) && in_ready) stream_ok++;
            end
            if (k < 8) begin
                in_valid = 1'b1; instr = 32'h00A08093; rs1_data = 32'd100 + 32'(k);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        chk("stream_count", 32'(stream_ok), 32'd8);

        // Illegal encodings
        send(32'h00000000, 32'd9, 32'd9);
        chk_out("illegal_zero", 32'd0, 32'd0, 4'd0, 5'd0, 1'b1);
        send(32'h022081B3, 32'd9, 32'd9);
        chk_out("illegal_f7", 32'd0, 32'd0, 4'd0, 5'd0, 1'b1);

        // Flush with both entries full; the concurrent input is dropped
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd20;
        step(); rs1_data = 32'd21;
        step();
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        flush = 1'b1; rs1_data = 32'd22;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready",  {31'b0, in_ready},  32'd1);

        // Asynchronous reset between edges
        in_valid = 1'b1; rs1_data = 32'd30;
        step(); rs1_data = 32'd31;
        step(); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_in_ready",  {31'b0, in_ready},  32'd1);
        chk("ar_A",         A, 32'd0);
        chk("ar_rd",        {27'b0, rd}, 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_after_valid", {31'b0, out_valid}, 32'd0);
        send(32'h002081B3, 32'd5, 32'd7);
        chk_out("ar_recover", 32'd5, 32'd7, 4'd0, 5'd3, 1'b0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
